// File: rtl/synth_param_pkg.sv
// Shared types for the synth parameter-bus writer: bank encoding, request word
// and writer FSM states.
package synth_param_pkg;

    localparam int PARAM_ADR_W  = 7;
    localparam int PARAM_DATA_W = 8;

    typedef enum logic [1:0] {
        OSC = 2'd0,
        COM = 2'd1,
        M1  = 2'd2,
        M2  = 2'd3
    } param_bank_e;

    typedef struct packed {
        param_bank_e             bank;
        logic [PARAM_ADR_W-1:0]  adr;
        logic [PARAM_DATA_W-1:0] data;
    } param_req_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } wr_state_e;

    // Bit 0 osc, bit 1 com, bit 2 m1, bit 3 m2.
    function automatic logic [3:0] bank_onehot(input param_bank_e bank);
        return 4'b0001 << bank;
    endfunction

endpackage

// File: rtl/param_wr_fifo.sv
// Synchronous FIFO of packed parameter requests; DEPTH must be a power of 2 (>= 2).
// Push while full and pop while empty are ignored.
module param_wr_fifo
    import synth_param_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  param_req_t din,
    input  logic       pop,
    output param_req_t dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit tells full from empty when the indices meet.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    param_req_t  mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/param_bus_writer.sv
// Drives the synth parameter bus: setup / active-low write strobe / hold per request.
// Optional request FIFO enabled with macro PARAM_WR_FIFO_EN (default: single holding register).
module param_bus_writer
    import synth_param_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    sCLK_XVXENVS,
    input  logic                    iRST,
    input  logic                    iREQ_VALID,
    input  logic [1:0]              iREQ_BANK,
    input  logic [PARAM_ADR_W-1:0]  iREQ_ADR,
    input  logic [PARAM_DATA_W-1:0] iREQ_DATA,
    output logic                    oREQ_READY,
    output logic [PARAM_DATA_W-1:0] data,
    output logic [PARAM_ADR_W-1:0]  adr,
    output logic                    write,
    output logic                    osc_sel,
    output logic                    com_sel,
    output logic                    m1_sel,
    output logic                    m2_sel,
    output logic                    oBUSY
);

    localparam int MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    wr_state_e        state;
    wr_state_e        state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [3:0]       sel_q;
    logic             pop;
    logic             pending;
    logic             accept;
    param_req_t       req_in;
    param_req_t       head;

    assign req_in = '{bank: param_bank_e'(iREQ_BANK), adr: iREQ_ADR, data: iREQ_DATA};
    assign accept = iREQ_VALID && oREQ_READY;

`ifdef PARAM_WR_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    param_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sCLK_XVXENVS),
        .rst   (iRST),
        .push  (accept),
        .din   (req_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pending    = !fifo_empty;
    assign oREQ_READY = !fifo_full;
`else
    logic hold_valid;

    // A pop only happens while hold_valid is set, when no accept is possible.
    always_ff @(posedge sCLK_XVXENVS) begin
        if (iRST) begin
            hold_valid <= 1'b0;
            head       <= '0;
        end else if (accept) begin
            hold_valid <= 1'b1;
            head       <= req_in;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign pending    = hold_valid;
    assign oREQ_READY = !hold_valid;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending) begin
                    state_n = SETUP;
                    cnt_n   = SETUP_LD;
                    pop     = 1'b1;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_n = STROBE;
                    cnt_n   = STROBE_LD;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_n = HOLD;
                    cnt_n   = HOLD_LD;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    if (pending) begin
                        state_n = SETUP;
                        cnt_n   = SETUP_LD;
                        pop     = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Bus outputs are registered so write, adr and selects switch glitch-free.
    always_ff @(posedge sCLK_XVXENVS) begin
        if (iRST) begin
            state <= IDLE;
            cnt   <= '0;
            write <= 1'b1;
            sel_q <= '0;
            adr   <= '0;
            data  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            write <= (state_n != STROBE);
            if (pop) begin
                sel_q <= bank_onehot(head.bank);
                adr   <= head.adr;
                data  <= head.data;
            end else if (state_n == IDLE) begin
                sel_q <= '0;
            end
        end
    end

    assign osc_sel = sel_q[0];
    assign com_sel = sel_q[1];
    assign m1_sel  = sel_q[2];
    assign m2_sel  = sel_q[3];
    assign oBUSY   = (state != IDLE) || pending;

endmodule

// File: tb/tb_param_bus_writer.sv
// Self-checking bench for param_bus_writer: a queue/countdown transaction model, a
// write-edge scoreboard and a bus stability monitor. Builds with or without PARAM_WR_FIFO_EN.
module tb_param_bus_writer;

    localparam int S     = 2;
    localparam int T     = 4;
    localparam int H     = 2;
    localparam int DEPTH = 4;
    localparam int TOTAL = S + T + H;
`ifdef PARAM_WR_FIFO_EN
    localparam bit FIFO_ON = 1'b1;
`else
    localparam bit FIFO_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_bank = '0;
    logic [6:0] req_adr = '0;
    logic [7:0] req_data = '0;
    logic       req_ready;
    logic [7:0] data;
    logic [6:0] adr;
    logic       write;
    logic       osc_sel, com_sel, m1_sel, m2_sel;
    logic       busy;
    logic [3:0] sel_obs;

    assign sel_obs = {m2_sel, m1_sel, com_sel, osc_sel};

    always #5 clk = ~clk;

    param_bus_writer #(
        .SETUP_CYC  (S),
        .STROBE_CYC (T),
        .HOLD_CYC   (H),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sCLK_XVXENVS (clk),
        .iRST         (rst),
        .iREQ_VALID   (req_valid),
        .iREQ_BANK    (req_bank),
        .iREQ_ADR     (req_adr),
        .iREQ_DATA    (req_data),
        .oREQ_READY   (req_ready),
        .data         (data),
        .adr          (adr),
        .write        (write),
        .osc_sel      (osc_sel),
        .com_sel      (com_sel),
        .m1_sel       (m1_sel),
        .m2_sel       (m2_sel),
        .oBUSY        (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_falls  = 0;

    // Request word: {bank[1:0], adr[6:0], data[7:0]}.
    logic [16:0] exp_q[$];
    logic [16:0] src_q[$];

    // Transaction model: waiting requests, cycles left in the current transaction,
    // and the bus values the current (or last) transaction put out.
    logic [16:0] m_q[$];
    int          m_rem = 0;
    logic [6:0]  m_adr = '0;
    logic [7:0]  m_data = '0;
    logic [3:0]  m_sel = '0;
    bit          m_acc = 1'b0;

    function automatic logic [3:0] onehot(input logic [1:0] b);
        return 4'b0001 << b;
    endfunction

    function automatic bit m_write();
        int el;
        el = TOTAL - m_rem;
        return !(m_rem > 0 && el >= S && el < S + T);
    endfunction

    function automatic bit m_ready();
        return FIFO_ON ? (m_q.size() < DEPTH) : (m_q.size() == 0);
    endfunction

    function automatic bit m_busy();
        return (m_rem > 0) || (m_q.size() > 0);
    endfunction

    task automatic model_step(input bit r, input bit v, input logic [16:0] req);
        logic [16:0] cur;
        bit rdy;
        if (r) begin
            m_q.delete();
            exp_q.delete();
            m_rem  = 0;
            m_adr  = '0;
            m_data = '0;
            m_sel  = '0;
            m_acc  = 1'b0;
            return;
        end
        rdy   = m_ready();
        m_acc = v && rdy;
        if (m_rem > 0) m_rem--;
        if (m_rem == 0) begin
            if (m_q.size() > 0) begin
                cur    = m_q.pop_front();
                m_rem  = TOTAL;
                m_sel  = onehot(cur[16:15]);
                m_adr  = cur[14:8];
                m_data = cur[7:0];
            end else begin
                m_sel = '0;
            end
        end
        if (m_acc) begin
            m_q.push_back(req);
            exp_q.push_back(req);
        end
    endtask

    task automatic set_inputs();
        logic [16:0] r;
        if (src_q.size() > 0) begin
            r         = src_q[0];
            req_valid = 1'b1;
            req_bank  = r[16:15];
            req_adr   = r[14:8];
            req_data  = r[7:0];
        end else begin
            req_valid = 1'b0;
            req_bank  = 2'($urandom_range(0, 3));
            req_adr   = 7'($urandom);
            req_data  = 8'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(rst, req_valid, {req_bank, req_adr, req_data});
        if (m_acc) void'(src_q.pop_front());
        #1;
        set_inputs();
    endtask

    function automatic logic [16:0] rand_req(input logic [1:0] b);
        return {b, 7'($urandom), 8'($urandom)};
    endfunction

    // Bus monitor: one-hot selects, frozen bus while strobed, issue order at each falling write.
    logic       prev_write = 1'b1;
    logic [3:0] prev_sel = '0;
    logic [6:0] prev_adr = '0;
    logic [7:0] prev_data = '0;

    always @(negedge clk) begin
        logic [16:0] e;
        n_checks++;
        if ($countones(sel_obs) > 1) begin
            n_fail++;
            $display("FAIL onehot_sel: sel=%b, at most one bit required", sel_obs);
        end
        if (write === 1'b0 && prev_write === 1'b0) begin
            n_checks++;
            if ({sel_obs, adr, data} !== {prev_sel, prev_adr, prev_data}) begin
                n_fail++;
                $display("FAIL stable_during_strobe: sel=%b adr=%h data=%h, required sel=%b adr=%h data=%h",
                         sel_obs, adr, data, prev_sel, prev_adr, prev_data);
            end
        end
        if (prev_write === 1'b1 && write === 1'b0) begin
            n_falls++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL issue_order: write pulse adr=%h data=%h sel=%b with no request outstanding",
                         adr, data, sel_obs);
            end else begin
                e = exp_q.pop_front();
                if ({sel_obs, adr, data} !== {onehot(e[16:15]), e[14:8], e[7:0]}) begin
                    n_fail++;
                    $display("FAIL issue_order: got sel=%b adr=%h data=%h, required sel=%b adr=%h data=%h",
                             sel_obs, adr, data, onehot(e[16:15]), e[14:8], e[7:0]);
                end
            end
        end
        prev_write = write;
        prev_sel   = sel_obs;
        prev_adr   = adr;
        prev_data  = data;
    end

    task automatic test_reset();
        rst = 1'b1;
        src_q.delete();
        set_inputs();
        tick();
        tick();
        n_checks++;
        if ({write, sel_obs, adr, data, req_ready, busy} !== {1'b1, 4'b0000, 7'h00, 8'h00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: w=%b sel=%b adr=%h data=%h rdy=%b busy=%b, required w=1 sel=0000 adr=00 data=00 rdy=1 busy=0",
                     write, sel_obs, adr, data, req_ready, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        bit exp_w, exp_osc;
        src_q.push_back({2'd0, 7'h12, 8'h55});
        set_inputs();
        for (int n = 0; n <= TOTAL + 4; n++) begin
            tick();
            exp_w   = !(n >= 1 + S && n <= S + T);
            exp_osc = (n >= 1 && n <= TOTAL);
            n_checks++;
            if (write !== exp_w || osc_sel !== exp_osc || (exp_osc && {adr, data} !== {7'h12, 8'h55})) begin
                n_fail++;
                $display("FAIL single_write cyc %0d: w=%b osc=%b adr=%h data=%h, required w=%b osc=%b adr=12 data=55",
                         n, write, osc_sel, adr, data, exp_w, exp_osc);
            end
            if (n > TOTAL) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_write_idle cyc %0d: busy=%b, required 0", n, busy);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int   falls[$];
        int   low_rdy = 0;
        logic pw = 1'b1;
        for (int b = 0; b < 4; b++) src_q.push_back(rand_req(2'(b)));
        set_inputs();
        for (int n = 0; n < 45; n++) begin
            tick();
            n_checks++;
            if ({write, sel_obs, adr, data, req_ready, busy} !== {m_write(), m_sel, m_adr, m_data, m_ready(), m_busy()}) begin
                n_fail++;
                $display("FAIL back_to_back cyc %0d: w=%b sel=%b adr=%h data=%h rdy=%b busy=%b, required w=%b sel=%b adr=%h data=%h rdy=%b busy=%b",
                         n, write, sel_obs, adr, data, req_ready, busy, m_write(), m_sel, m_adr, m_data, m_ready(), m_busy());
            end
            if (pw && !write) falls.push_back(n);
            if (!req_ready) low_rdy++;
            pw = write;
        end
        n_checks++;
        if (falls.size() != 4 || falls[0] != 1 + S) begin
            n_fail++;
            $display("FAIL back_to_back_falls: %0d falls, first at cyc %0d; required 4 falls, first at cyc %0d",
                     falls.size(), (falls.size() > 0) ? falls[0] : -1, 1 + S);
        end
        for (int i = 1; i < falls.size(); i++) begin
            n_checks++;
            if (falls[i] - falls[i-1] != TOTAL) begin
                n_fail++;
                $display("FAIL back_to_back_spacing: fall %0d after %0d cycles, required %0d",
                         i, falls[i] - falls[i-1], TOTAL);
            end
        end
`ifdef PARAM_WR_FIFO_EN
        n_checks++;
        if (low_rdy != 0) begin
            n_fail++;
            $display("FAIL back_to_back_ready: ready low for %0d cycles, required 0", low_rdy);
        end
`endif
    endtask

    task automatic test_held_valid();
        int low_rdy = 0;
        int f0;
        f0 = n_falls;
        for (int i = 0; i < 6; i++) src_q.push_back(rand_req(2'($urandom_range(0, 3))));
        set_inputs();
        for (int n = 0; n < 6 * TOTAL + 12; n++) begin
            tick();
            n_checks++;
            if ({write, sel_obs, adr, data, req_ready, busy} !== {m_write(), m_sel, m_adr, m_data, m_ready(), m_busy()}) begin
                n_fail++;
                $display("FAIL held_valid cyc %0d: w=%b sel=%b adr=%h data=%h rdy=%b busy=%b, required w=%b sel=%b adr=%h data=%h rdy=%b busy=%b",
                         n, write, sel_obs, adr, data, req_ready, busy, m_write(), m_sel, m_adr, m_data, m_ready(), m_busy());
            end
            if (!req_ready) low_rdy++;
        end
        @(negedge clk);
        n_checks++;
        if (low_rdy == 0 || n_falls - f0 != 6 || exp_q.size() != 0 || src_q.size() != 0) begin
            n_fail++;
            $display("FAIL held_valid_summary: ready-low cycles=%0d pulses=%0d outstanding=%0d unsent=%0d, required >0/6/0/0",
                     low_rdy, n_falls - f0, exp_q.size(), src_q.size());
        end
    endtask

    task automatic test_reset_mid_strobe();
        bit found = 1'b0;
        int f0;
        for (int i = 0; i < 3; i++) src_q.push_back(rand_req(2'($urandom_range(0, 3))));
        set_inputs();
        for (int n = 0; n < 30 && !found; n++) begin
            tick();
            n_checks++;
            if ({write, sel_obs, adr, data, req_ready, busy} !== {m_write(), m_sel, m_adr, m_data, m_ready(), m_busy()}) begin
                n_fail++;
                $display("FAIL mid_strobe_pre cyc %0d: w=%b sel=%b adr=%h data=%h rdy=%b busy=%b, required w=%b sel=%b adr=%h data=%h rdy=%b busy=%b",
                         n, write, sel_obs, adr, data, req_ready, busy, m_write(), m_sel, m_adr, m_data, m_ready(), m_busy());
            end
            if (m_rem > 0 && TOTAL - m_rem == S + 1) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL mid_strobe_wait: second strobe cycle not reached within 30 cycles");
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        src_q.delete();
        set_inputs();
        f0 = n_falls;
        n_checks++;
        if ({write, sel_obs, req_ready, busy} !== {1'b1, 4'b0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_strobe_reset: w=%b sel=%b rdy=%b busy=%b, required w=1 sel=0000 rdy=1 busy=0",
                     write, sel_obs, req_ready, busy);
        end
        repeat (20) tick();
        @(negedge clk);
        n_checks++;
        if (n_falls != f0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_strobe_after: %0d write pulses busy=%b, required 0 pulses busy=0", n_falls - f0, busy);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            if (n < 240 && src_q.size() < 3 && $urandom_range(0, 3) == 0) begin
                src_q.push_back(rand_req(2'($urandom_range(0, 3))));
                set_inputs();
            end
            tick();
            n_checks++;
            if ({write, sel_obs, adr, data, req_ready, busy} !== {m_write(), m_sel, m_adr, m_data, m_ready(), m_busy()}) begin
                n_fail++;
                $display("FAIL random cyc %0d: w=%b sel=%b adr=%h data=%h rdy=%b busy=%b, required w=%b sel=%b adr=%h data=%h rdy=%b busy=%b",
                         n, write, sel_obs, adr, data, req_ready, busy, m_write(), m_sel, m_adr, m_data, m_ready(), m_busy());
            end
        end
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || src_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL random_drain: outstanding=%0d unsent=%0d busy=%b, required 0/0/0",
                     exp_q.size(), src_q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_held_valid();
        test_reset_mid_strobe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/param_bus_writer.md
PARAM_BUS_WRITER -- requirements
Module: param_bus_writer

Interface
REQ-001 The block SHALL have parameter SETUP_CYC, default 2: cycles that adr, data and the select lines are stable before write falls (min 1).
REQ-002 The block SHALL have parameter STROBE_CYC, default 4: cycles that write is held low (min 1).
REQ-003 The block SHALL have parameter HOLD_CYC, default 2: cycles that adr, data and the select lines are held after write rises (min 1).
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4: request queue depth, a power of 2, used only when PARAM_WR_FIFO_EN is defined.
REQ-005 The block SHALL have one clock and a synchronous active-high reset:
  sCLK_XVXENVS  in   1  sole clock; all state updates on the rising edge.
  iRST          in   1  synchronous active-high reset.
REQ-006 The request side SHALL be:
  iREQ_VALID  in   1  request present.
  iREQ_BANK   in   2  target bank: 0 osc, 1 com, 2 m1, 3 m2.
  iREQ_ADR    in   7  parameter address.
  iREQ_DATA   in   8  parameter value.
  oREQ_READY  out  1  request accepted on an edge where iREQ_VALID and oREQ_READY are both high.
REQ-007 The parameter bus side SHALL be:
  data      out  8  parameter value.
  adr       out  7  parameter address.
  write     out  1  active-low strobe; the receiver latches on its falling edge.
  osc_sel   out  1  one-hot bank select, osc.
  com_sel   out  1  one-hot bank select, com.
  m1_sel    out  1  one-hot bank select, m1.
  m2_sel    out  1  one-hot bank select, m2.
  oBUSY     out  1  high when the FSM is not IDLE or any request is pending.

Function
REQ-008 The FSM SHALL have four states: IDLE, SETUP, STROBE and HOLD, with a down-counter loaded on each state entry.
REQ-009 IDLE SHALL go to SETUP on the edge after a request is pending, at which edge the request is popped and adr, data and sel are loaded.
REQ-010 SETUP SHALL last SETUP_CYC cycles with write=1, STROBE SHALL last STROBE_CYC cycles with write=0, and HOLD SHALL last HOLD_CYC cycles with write=1.
REQ-011 At HOLD end, if a request is pending the FSM SHALL go directly to SETUP and load the new request; otherwise it SHALL go to IDLE.
REQ-012 In IDLE all select lines SHALL be 0 and adr/data SHALL retain their last values.
REQ-013 Exactly one select line SHALL be high, the one chosen by iREQ_BANK, throughout SETUP, STROBE and HOLD.
REQ-014 adr, data and the select lines SHALL NOT change while write=0 or during HOLD; they SHALL change only on entry to SETUP or IDLE.
REQ-015 Latency: for a request accepted at edge 0 with the block idle, SETUP outputs SHALL appear after edge 1 and write SHALL fall after edge 1+SETUP_CYC.
REQ-016 Back-to-back requests SHALL start one transaction every SETUP_CYC+STROBE_CYC+HOLD_CYC cycles.
REQ-017 iREQ_ADR and iREQ_DATA SHALL be passed through unmodified, with no range filtering (for example, com with adr≠1 is still written).
REQ-018 Requests SHALL be issued in acceptance order; none SHALL be dropped or duplicated.
REQ-019 A request accepted on the same edge that a pop frees an entry SHALL be accepted; oREQ_READY SHALL be derived only from registered state.

Reset
REQ-020 On iRST the block SHALL go to IDLE and set write=1, all select lines=0, adr=0, data=0, oREQ_READY=1 and oBUSY=0, and flush the queue.
REQ-021 iRST asserted mid-STROBE SHALL force write=1 on that edge, abort the transaction and discard all queued requests.

Configuration
REQ-022 With macro PARAM_WR_FIFO_EN defined, requests SHALL be queued in a FIFO_DEPTH-entry FIFO and oREQ_READY SHALL equal not full.
REQ-023 Without PARAM_WR_FIFO_EN, the block SHALL use a single holding register and oREQ_READY SHALL be high only when the holding register is empty.
REQ-024 The REQ-015 latency SHALL be identical in both configurations.

Structure
REQ-025 Package synth_param_pkg SHALL hold the bank enum typedef (OSC, COM, M1, M2), PARAM_ADR_W=7, PARAM_DATA_W=8 and a packed request struct {bank, adr, data}.
REQ-026 Sub-module param_wr_fifo SHALL implement the synchronous FIFO of packed requests with push/pop/full/empty, instantiated only under PARAM_WR_FIFO_EN.

Verification
REQ-027 Single write with defaults (bank 0, adr 0x12, data 0x55): osc_sel=1 and adr/data valid from cycle 1, write low in cycles 3-6, osc_sel=0 from cycle 9, oBUSY=0 after.
REQ-028 Four back-to-back requests with FIFO on (banks 0,1,2,3): four falling edges of write spaced 8 cycles apart, correct one-hot select each time, oREQ_READY never low.
REQ-029 Six requests held valid with FIFO on (depth 4): oREQ_READY deasserts while full and all six emerge in order, none lost.
REQ-030 Six requests held valid with FIFO off: oREQ_READY=0 from acceptance until HOLD end, the next request is accepted then, and order is preserved.
REQ-031 iRST pulsed in the second STROBE cycle with 2 requests queued: write=1 and selects=0 on the next edge, no further write pulses, oBUSY=0.
REQ-032 Checker on all tests: adr/data/sel stable whenever write=0, and never more than one select high at any time.
